// File: rtl/seq_pkg.sv
// Shared definitions for the pattern serializer: FSM state encoding and
// the index-width helper that sizes the IDX port and the prescaler counter.
package seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic int unsigned idx_width(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/seq_serializer_bit_tick.sv
// Bit-period prescaler: counts 0..DIV-1 and flags the terminal count so the
// serializer knows when to move to the next bit.
module bit_tick
   import seq_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = idx_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt <= '0;
      end else if (clear || tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/seq_serializer.sv
// Shifts a latched switch pattern out on X, one bit per DIV cycles, LSB- or
// MSB-first. Define SEQ_SERIALIZER_PARITY_EN to append an even-parity bit.
module seq_serializer
   import seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 1
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic [WIDTH-1:0]              PATTERN,
   input  logic                          START,
   input  logic                          ABORT,
   input  logic                          MSB_FIRST,
   input  logic                          LOOP,
   output logic                          X,
   output logic [WIDTH-1:0]              LEDS,
   output logic [idx_width(WIDTH)-1:0]   IDX,
   output logic                          BUSY,
   output logic                          DONE
);

   localparam int unsigned IW = idx_width(WIDTH);
   localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_shadow;
   logic             r_msb;
   logic [IW-1:0]    r_idx;
   logic             r_done;
`ifdef SEQ_SERIALIZER_PARITY_EN
   logic             r_par;
`endif

   logic          w_tick;
   logic          w_last_bit;
   logic          w_frame_end;
   logic [IW-1:0] w_first;
   logic [IW-1:0] w_next;

   // Held clear in IDLE so every frame starts on a fresh bit period.
   bit_tick #(.DIV(DIV)) u_tick (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clear (r_state == ST_IDLE),
      .tick  (w_tick)
   );

   assign w_first    = MSB_FIRST ? IDX_TOP : '0;
   assign w_next     = r_msb ? (r_idx - IW'(1)) : (r_idx + IW'(1));
   assign w_last_bit = r_msb ? (r_idx == '0) : (r_idx == IDX_TOP);
`ifdef SEQ_SERIALIZER_PARITY_EN
   assign w_frame_end = w_tick && r_par;
`else
   assign w_frame_end = w_tick && w_last_bit;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= ST_IDLE;
         r_shadow <= '0;
         r_msb    <= 1'b0;
         r_idx    <= '0;
         r_done   <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
         r_par    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (START && !ABORT) begin
                  r_state  <= ST_RUN;
                  r_shadow <= PATTERN;
                  r_msb    <= MSB_FIRST;
                  r_idx    <= w_first;
               end
            end
            ST_RUN: begin
               if (ABORT) begin
                  r_state <= ST_IDLE;
                  r_idx   <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
                  r_par   <= 1'b0;
`endif
               end else if (w_frame_end) begin
                  r_done <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
                  r_par  <= 1'b0;
`endif
                  if (LOOP) begin
                     r_shadow <= PATTERN;
                     r_msb    <= MSB_FIRST;
                     r_idx    <= w_first;
                  end else begin
                     r_state <= ST_IDLE;
                     r_idx   <= '0;
                  end
               end else if (w_tick) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                  // IDX parks on the last data bit while parity is shifted out.
                  if (w_last_bit) r_par <= 1'b1;
                  else            r_idx <= w_next;
`else
                  r_idx <= w_next;
`endif
               end
            end
         endcase
      end
   end

   always_comb begin
      X    = 1'b0;
      LEDS = '0;
      IDX  = '0;
      if (r_state == ST_RUN) begin
         IDX = r_idx;
`ifdef SEQ_SERIALIZER_PARITY_EN
         if (r_par) begin
            X = ^r_shadow;
         end else begin
            X    = r_shadow[r_idx];
            LEDS = WIDTH'(1) << r_idx;
         end
`else
         X    = r_shadow[r_idx];
         LEDS = WIDTH'(1) << r_idx;
`endif
      end
   end

   assign BUSY = (r_state == ST_RUN);
   assign DONE = r_done;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer at WIDTH=6 with DIV=1 and DIV=3 instances;
// frame length follows SEQ_SERIALIZER_PARITY_EN.
module tb_seq_serializer;

`ifdef SEQ_SERIALIZER_PARITY_EN
   localparam int FL = 7;
`else
   localparam int FL = 6;
`endif

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [5:0] PATTERN;
   logic       START1, START3, ABORT, MSB_FIRST, LOOP;
   logic       x1, busy1, done1, x3, busy3, done3;
   logic [5:0] leds1, leds3;
   logic [2:0] idx1, idx3;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   seq_serializer #(.WIDTH(6), .DIV(1)) u_d1 (
      .CLK(CLK), .RST_N(RST_N), .PATTERN(PATTERN), .START(START1), .ABORT(ABORT),
      .MSB_FIRST(MSB_FIRST), .LOOP(LOOP), .X(x1), .LEDS(leds1), .IDX(idx1),
      .BUSY(busy1), .DONE(done1)
   );

   seq_serializer #(.WIDTH(6), .DIV(3)) u_d3 (
      .CLK(CLK), .RST_N(RST_N), .PATTERN(PATTERN), .START(START3), .ABORT(ABORT),
      .MSB_FIRST(MSB_FIRST), .LOOP(LOOP), .X(x3), .LEDS(leds3), .IDX(idx3),
      .BUSY(busy3), .DONE(done3)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected DIV=1 outputs at position c (0-based) of a frame.
   task automatic chk_bit(input string tag, input logic [5:0] pat, input logic msb,
                          input int c, input logic edone);
      logic       ex;
      logic [5:0] el;
      logic [2:0] ei;
      int         i;
      if (c < 6) begin
         i  = msb ? 5 - c : c;
         ex = pat[i];
         el = 6'd1 << i;
         ei = 3'(i);
      end else begin
         ex = ^pat;
         el = '0;
         ei = msb ? 3'd0 : 3'd5;
      end
      chk({tag, "_x"},    32'(x1),    32'(ex));
      chk({tag, "_leds"}, 32'(leds1), 32'(el));
      chk({tag, "_idx"},  32'(idx1),  32'(ei));
      chk({tag, "_busy"}, 32'(busy1), 32'(1'b1));
      chk({tag, "_done"}, 32'(done1), 32'(edone));
   endtask

   task automatic chk_idle1(input string tag, input logic edone);
      chk({tag, "_x"},    32'(x1),    32'(1'b0));
      chk({tag, "_leds"}, 32'(leds1), 32'(6'h00));
      chk({tag, "_idx"},  32'(idx1),  32'(3'd0));
      chk({tag, "_busy"}, 32'(busy1), 32'(1'b0));
      chk({tag, "_done"}, 32'(done1), 32'(edone));
   endtask

   task automatic run_frame(input string tag, input logic [5:0] pat, input logic msb);
      PATTERN   = pat;
      MSB_FIRST = msb;
      LOOP      = 1'b0;
      START1    = 1'b1;
      step();
      START1 = 1'b0;
      for (int c = 0; c < FL; c++) begin
         chk_bit($sformatf("%s_c%0d", tag, c + 1), pat, msb, c, 1'b0);
         step();
      end
      chk_idle1({tag, "_end"}, 1'b1);
      step();
      chk_idle1({tag, "_post"}, 1'b0);
   endtask

   initial begin
      RST_N = 1'b0; PATTERN = '0; START1 = 1'b0; START3 = 1'b0;
      ABORT = 1'b0; MSB_FIRST = 1'b0; LOOP = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk_idle1("rst_d1", 1'b0);
      chk("rst_d3_x",    32'(x3),    32'(1'b0));
      chk("rst_d3_leds", 32'(leds3), 32'(6'h00));
      chk("rst_d3_busy", 32'(busy3), 32'(1'b0));
      chk("rst_d3_done", 32'(done3), 32'(1'b0));
      RST_N = 1'b1;
      step();

      // Basic frames, both bit orders, plus the parity-carrying pattern.
      run_frame("lsb", 6'b101101, 1'b0);
      run_frame("msb", 6'b101101, 1'b1);
      run_frame("msb2", 6'b110100, 1'b1);
      run_frame("par", 6'b000111, 1'b0);

      // DIV=3: each bit held three cycles.
      PATTERN = 6'b000001; MSB_FIRST = 1'b0; START3 = 1'b1;
      step();
      START3 = 1'b0;
      for (int c = 1; c <= 3 * FL; c++) begin
         int b;
         logic ex;
         b  = (c - 1) / 3;
         ex = (b < 6) ? PATTERN[b] : ^PATTERN;
         chk($sformatf("div3_c%0d_x", c),    32'(x3),    32'(ex));
         chk($sformatf("div3_c%0d_busy", c), 32'(busy3), 32'(1'b1));
         chk($sformatf("div3_c%0d_done", c), 32'(done3), 32'(1'b0));
         step();
      end
      chk("div3_end_done", 32'(done3), 32'(1'b1));
      chk("div3_end_busy", 32'(busy3), 32'(1'b0));
      chk("div3_end_x",    32'(x3),    32'(1'b0));

      // LOOP: pattern change mid-frame only affects the following frame.
      PATTERN = 6'h2A; MSB_FIRST = 1'b0; LOOP = 1'b1; START1 = 1'b1;
      step();
      START1 = 1'b0;
      for (int c = 0; c < FL; c++) begin
         chk_bit($sformatf("loop1_c%0d", c + 1), 6'h2A, 1'b0, c, 1'b0);
         if (c == 2) PATTERN = 6'h15;
         step();
      end
      for (int c = 0; c < FL; c++) begin
         chk_bit($sformatf("loop2_c%0d", c + 1), 6'h15, 1'b0, c, (c == 0));
         if (c == 1) LOOP = 1'b0;
         step();
      end
      chk_idle1("loop_end", 1'b1);
      step();

      // START held high: restarts one cycle after returning to IDLE.
      PATTERN = 6'h3C; MSB_FIRST = 1'b0; START1 = 1'b1;
      step();
      for (int c = 0; c < FL; c++) begin
         chk_bit($sformatf("hold_c%0d", c + 1), 6'h3C, 1'b0, c, 1'b0);
         step();
      end
      chk_idle1("hold_end", 1'b1);
      step();
      chk_bit("hold_restart", 6'h3C, 1'b0, 0, 1'b0);
      START1 = 1'b0; ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      chk_idle1("hold_abort", 1'b0);
      step();

      // ABORT at bit 3 together with START.
      PATTERN = 6'b101101; MSB_FIRST = 1'b0; START1 = 1'b1;
      step();
      START1 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk_bit($sformatf("abt_c%0d", c + 1), 6'b101101, 1'b0, c, 1'b0);
         if (c < 3) step();
      end
      ABORT = 1'b1; START1 = 1'b1;
      step();
      chk_idle1("abt_next", 1'b0);
      ABORT = 1'b0; START1 = 1'b0;
      for (int c = 0; c < FL + 2; c++) begin
         step();
         chk_idle1($sformatf("abt_after%0d", c), 1'b0);
      end

      // Asynchronous reset mid-frame.
      PATTERN = 6'h3F; START1 = 1'b1;
      step();
      START1 = 1'b0;
      step();
      step();
      chk_bit("rmid_pre", 6'h3F, 1'b0, 2, 1'b0);
      RST_N = 1'b0;
      #1;
      chk_idle1("rmid_now", 1'b0);
      #2;
      RST_N = 1'b1;
      for (int c = 0; c < FL + 2; c++) begin
         step();
         chk_idle1($sformatf("rmid_after%0d", c), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
